vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
Transaction controller for the 2-unit / 6-unit vending path.
- Accumulates coin credit and latches the item selection.
- Checks the price on confirm, then issues a single dispense pulse for the chosen item.
- Returns the remaining credit as a train of 1-unit change pulses.
- Sits between the coin/keypad inputs and the dispense/change actuators, and owns all credit bookkeeping.

Parameters:
PRICE2, 2, price of item A (get2)
PRICE6, 6, price of item B (get6)
CREDIT_W, 4, credit register width
MAX_CREDIT, 15, credit saturation limit; must be ≤ 2^CREDIT_W-1 and ≥ PRICE6

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
coin1  in  1  one-cycle pulse, 1-unit coin inserted
coin5  in  1  one-cycle pulse, 5-unit coin inserted
sel2  in  1  select item A
sel6  in  1  select item B
sure  in  1  confirm purchase
cancel  in  1  abort transaction, refund credit
get2  out  1  dispense item A, one-cycle pulse
get6  out  1  dispense item B, one-cycle pulse
change1  out  1  high one cycle per 1-unit coin returned
coin_rej  out  1  one-cycle pulse, coin(s) rejected this cycle
err  out  1  one-cycle pulse, confirm refused
busy  out  1  high in DISPENSE/REFUND
credit  out  CREDIT_W  current credit, registered

Behaviour:
- Reset: state=IDLE, credit=0, selection=NONE; all outputs 0 on the cycle after rst is sampled high. Reset mid-DISPENSE/REFUND abandons the transaction and loses the credit. rst has priority over every input.
- States:
  - IDLE: credit=0 and selection=NONE.
  - COLLECT: credit>0 or a selection is held.
  - DISPENSE: one cycle.
  - REFUND: change is being returned.
- All outputs are registered. Response appears on the cycle after the input is sampled.
- Priority in IDLE/COLLECT: cancel > sure > sel > coins.
- Coins:
  - Add coin1 + 5·coin5; both high adds 6.
  - If credit+add > MAX_CREDIT, the whole add is rejected: credit unchanged, coin_rej=1.
  - Coins in a cycle where sure or cancel is high are rejected with coin_rej=1.
  - Coins in DISPENSE/REFUND are rejected with coin_rej=1.
- Selection:
  - sel2 alone → A; sel6 alone → B.
  - Both high → selection unchanged.
  - A later selection overwrites an earlier one.
  - Selection alone moves IDLE→COLLECT.
- sure:
  - Selection valid and credit ≥ price: credit -= price, go to DISPENSE.
  - Otherwise (no selection or insufficient credit): err=1, state/credit/selection unchanged.
- DISPENSE:
  - get2 or get6 = 1 for exactly this one registered cycle; selection cleared.
  - Next state: REFUND if credit>0, else IDLE.
- cancel (IDLE/COLLECT):
  - Selection cleared.
  - credit>0 → REFUND; otherwise → IDLE.
- REFUND:
  - change1=1 and credit decrements by 1 every cycle.
  - Exits to IDLE on the cycle credit reaches 0. Total change1 cycles equal the credit on entry.
- In DISPENSE/REFUND, sel/sure/cancel are ignored and produce no err.
- busy=1 exactly while state is DISPENSE or REFUND.
- get2, get6 and change1 are never high in the same cycle.
- Arithmetic: credit is unsigned CREDIT_W; compare in CREDIT_W+1 bits; no wrap permitted.

Decomposition:
- vend_pkg holds:
  - state enum: IDLE, COLLECT, DISPENSE, REFUND;
  - selection enum: NONE, A, B;
  - coin values 1 and 5;
  - default prices.
- One sub-module, vend_credit: saturating credit register with add/sub/decrement, overflow-reject and ≥-price compare.
- The FSM stays in vend_ctrl.

Test Plan:
1. coin5, coin1, sel6, sure → get6 pulse one cycle; credit 6→0; no change1; back to IDLE; busy high 1 cycle.
2. coin5, coin5, sel2, sure → get2 pulse; credit 8 after dispense; then change1 high 8 consecutive cycles; credit 0; IDLE.
3. coin1, sel6, sure → err pulse; no get6; credit stays 1; state COLLECT.
4. credit=5 with sel2, cancel and sure same cycle → cancel wins; no get2; change1 5 cycles.
5. credit=14, coin5 → coin_rej, credit 14; then coin1 → credit 15; then coin1 → coin_rej, credit 15.
6. rst asserted on 3rd cycle of an 8-cycle refund → next cycle change1=0, credit=0, busy=0, IDLE; no further pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
// Holds the FSM/selection encodings, coin values and default prices.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_REFUND   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } sel_e;

    localparam int COIN1_VAL  = 1;
    localparam int COIN5_VAL  = 5;
    localparam int PRICE2_DEF = 2;
    localparam int PRICE6_DEF = 6;

    // Value added by the coins present this cycle; both together add 6.
    function automatic logic [3:0] coin_value(input logic c1, input logic c5);
        logic [3:0] v1;
        logic [3:0] v5;
        v1 = c1 ? 4'(COIN1_VAL) : 4'd0;
        v5 = c5 ? 4'(COIN5_VAL) : 4'd0;
        return v1 + v5;
    endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit register: guarded add, price subtract and refund decrement.
// Never wraps; all compares are done one bit wider than the register.
module vend_credit
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                add_en_i,
    input  logic [CREDIT_W-1:0] add_val_i,
    input  logic                sub_en_i,
    input  logic [CREDIT_W-1:0] sub_val_i,
    input  logic                dec_en_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                add_fits_o,
    output logic                covers_o,
    output logic                nonzero_o
);

    localparam logic [CREDIT_W:0]   MAX_W  = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] ZERO_C = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W-1:0] ONE_C  = {{(CREDIT_W-1){1'b0}}, 1'b1};

    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic [CREDIT_W:0]   sum_s;

    assign sum_s      = {1'b0, credit_q} + {1'b0, add_val_i};
    assign add_fits_o = (sum_s <= MAX_W);
    assign covers_o   = ({1'b0, credit_q} >= {1'b0, sub_val_i});
    assign nonzero_o  = (credit_q != ZERO_C);
    assign credit_o   = credit_q;

    // Next credit; each operation re-checks its own bound so nothing can wrap.
    always_comb begin
        credit_d = credit_q;
        if (clr_i) begin
            credit_d = ZERO_C;
        end else if (sub_en_i && covers_o) begin
            credit_d = credit_q - sub_val_i;
        end else if (dec_en_i && nonzero_o) begin
            credit_d = credit_q - ONE_C;
        end else if (add_en_i && add_fits_o) begin
            credit_d = sum_s[CREDIT_W-1:0];
        end else begin
            credit_d = credit_q;
        end
    end

    // Credit storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= ZERO_C;
        end else begin
            credit_q <= credit_d;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction FSM: collects credit and a selection, dispenses on
// confirm and pays back remaining credit as 1-unit change pulses.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE2     = PRICE2_DEF,
    parameter int PRICE6     = PRICE6_DEF,
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin1,
    input  logic                coin5,
    input  logic                sel2,
    input  logic                sel6,
    input  logic                sure,
    input  logic                cancel,
    output logic                get2,
    output logic                get6,
    output logic                change1,
    output logic                coin_rej,
    output logic                err,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] ONE_C = {{(CREDIT_W-1){1'b0}}, 1'b1};

    state_e state_q, state_d;
    sel_e   sel_q, sel_d;
    logic   get2_q, get2_d;
    logic   get6_q, get6_d;
    logic   change1_q, change1_d;
    logic   coin_rej_q, coin_rej_d;
    logic   err_q, err_d;
    logic   busy_q, busy_d;

    logic                coin_any_s;
    logic [CREDIT_W-1:0] add_val_s;
    logic [CREDIT_W-1:0] price_s;
    logic [CREDIT_W-1:0] credit_s;
    logic                add_en_s, sub_en_s, dec_en_s, clr_s;
    logic                add_fits_s, covers_s, nonzero_s;

    assign coin_any_s = coin1 | coin5;
    assign add_val_s  = CREDIT_W'(coin_value(coin1, coin5));
    assign price_s    = (sel_q == SEL_B) ? CREDIT_W'(PRICE6) : CREDIT_W'(PRICE2);

    vend_credit #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_s),
        .add_en_i   (add_en_s),
        .add_val_i  (add_val_s),
        .sub_en_i   (sub_en_s),
        .sub_val_i  (price_s),
        .dec_en_i   (dec_en_s),
        .credit_o   (credit_s),
        .add_fits_o (add_fits_s),
        .covers_o   (covers_s),
        .nonzero_o  (nonzero_s)
    );

    // Next-state decode; priority in IDLE/COLLECT is cancel > sure > sel > coins.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        add_en_s   = 1'b0;
        sub_en_s   = 1'b0;
        dec_en_s   = 1'b0;
        clr_s      = 1'b0;
        coin_rej_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (cancel) begin
                    sel_d      = SEL_NONE;
                    coin_rej_d = coin_any_s;
                    state_d    = nonzero_s ? ST_REFUND : ST_IDLE;
                end else if (sure) begin
                    coin_rej_d = coin_any_s;
                    if ((sel_q != SEL_NONE) && covers_s) begin
                        sub_en_s = 1'b1;
                        state_d  = ST_DISPENSE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    if (sel2 && !sel6) begin
                        sel_d = SEL_A;
                    end else if (sel6 && !sel2) begin
                        sel_d = SEL_B;
                    end else begin
                        sel_d = sel_q;
                    end
                    if (coin_any_s) begin
                        add_en_s   = add_fits_s;
                        coin_rej_d = !add_fits_s;
                    end else begin
                        add_en_s = 1'b0;
                    end
                    state_d = (add_en_s || nonzero_s || (sel_d != SEL_NONE)) ? ST_COLLECT : ST_IDLE;
                end
            end
            ST_DISPENSE: begin
                sel_d      = SEL_NONE;
                coin_rej_d = coin_any_s;
                state_d    = nonzero_s ? ST_REFUND : ST_IDLE;
            end
            ST_REFUND: begin
                coin_rej_d = coin_any_s;
                dec_en_s   = 1'b1;
                state_d    = (credit_s <= ONE_C) ? ST_IDLE : ST_REFUND;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_NONE;
                clr_s   = 1'b1;
            end
        endcase
    end

    // Outputs describe the state being entered, so they line up with it.
    always_comb begin
        get2_d    = (state_d == ST_DISPENSE) && (sel_q == SEL_A);
        get6_d    = (state_d == ST_DISPENSE) && (sel_q == SEL_B);
        change1_d = (state_d == ST_REFUND);
        busy_d    = (state_d == ST_DISPENSE) || (state_d == ST_REFUND);
    end

    // FSM state, selection and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_NONE;
            get2_q     <= 1'b0;
            get6_q     <= 1'b0;
            change1_q  <= 1'b0;
            coin_rej_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            get2_q     <= get2_d;
            get6_q     <= get6_d;
            change1_q  <= change1_d;
            coin_rej_q <= coin_rej_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign get2     = get2_q;
    assign get6     = get6_q;
    assign change1  = change1_q;
    assign coin_rej = coin_rej_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign credit   = credit_s;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl; expected values are hand-derived.
module tb_vend_ctrl;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin1 = 1'b0, coin5 = 1'b0, sel2 = 1'b0, sel6 = 1'b0, sure = 1'b0, cancel = 1'b0;
    logic       get2, get6, change1, coin_rej, err, busy;
    logic [3:0] credit;

    int n_checks = 0;
    int n_fail   = 0;

    vend_ctrl dut (
        .clk(clk), .rst(rst), .coin1(coin1), .coin5(coin5), .sel2(sel2), .sel6(sel6),
        .sure(sure), .cancel(cancel), .get2(get2), .get6(get6), .change1(change1),
        .coin_rej(coin_rej), .err(err), .busy(busy), .credit(credit)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs held, then inputs return to 0; outputs sampled 1ns after the edge.
    task automatic step(input logic c1, input logic c5, input logic s2, input logic s6,
                        input logic su, input logic ca);
        coin1 = c1; coin5 = c5; sel2 = s2; sel6 = s6; sure = su; cancel = ca;
        @(posedge clk);
        #1;
        coin1 = 1'b0; coin5 = 1'b0; sel2 = 1'b0; sel6 = 1'b0; sure = 1'b0; cancel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (credit !== 4'd0) begin n_fail++; $display("FAIL reset_credit: got %0d expected 0", credit); end
        n_checks++; if ({get2, get6, change1, coin_rej, err, busy} !== 6'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 000000", {get2, get6, change1, coin_rej, err, busy}); end
        n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_exact_get6();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (credit !== 4'd5) begin n_fail++; $display("FAIL t1_coin5: got %0d expected 5", credit); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (credit !== 4'd6) begin n_fail++; $display("FAIL t1_credit6: got %0d expected 6", credit); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if ({get6, get2, change1, busy} !== 4'b1001) begin n_fail++; $display("FAIL t1_dispense: got %b expected 1001", {get6, get2, change1, busy}); end
        n_checks++; if (credit !== 4'd0) begin n_fail++; $display("FAIL t1_credit0: got %0d expected 0", credit); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({get6, change1, busy} !== 3'b000) begin n_fail++; $display("FAIL t1_after: got %b expected 000", {get6, change1, busy}); end
        n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL t1_idle: got %0d expected %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_get2_refund();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if ({get2, get6, change1} !== 3'b100) begin n_fail++; $display("FAIL t2_get2: got %b expected 100", {get2, get6, change1}); end
        n_checks++; if (credit !== 4'd8) begin n_fail++; $display("FAIL t2_credit8: got %0d expected 8", credit); end
        for (int i = 0; i < 8; i++) begin
            // a coin in the middle of the refund must bounce off without touching credit
            step((i == 2) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++; if ({change1, busy, get2} !== 3'b110) begin n_fail++; $display("FAIL t2_refund_flags: cycle %0d got %b expected 110", i, {change1, busy, get2}); end
            n_checks++; if (credit !== 4'(8 - i)) begin n_fail++; $display("FAIL t2_refund_credit: cycle %0d got %0d expected %0d", i, credit, 8 - i); end
            if (i == 2) begin
                n_checks++; if (coin_rej !== 1'b1) begin n_fail++; $display("FAIL t2_coin_rej_busy: got %b expected 1", coin_rej); end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({change1, busy, credit} !== 6'b0) begin n_fail++; $display("FAIL t2_done: got %b expected 000000", {change1, busy, credit}); end
        n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL t2_idle: got %0d expected %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_err();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if ({err, get6, busy} !== 3'b100) begin n_fail++; $display("FAIL t3_err: got %b expected 100", {err, get6, busy}); end
        n_checks++; if (credit !== 4'd1) begin n_fail++; $display("FAIL t3_credit: got %0d expected 1", credit); end
        n_checks++; if (dut.state_q !== ST_COLLECT) begin n_fail++; $display("FAIL t3_state: got %0d expected %0d", dut.state_q, ST_COLLECT); end
        // both selects together must leave B in place
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if ((err !== 1'b0) || (dut.sel_q !== SEL_B)) begin n_fail++; $display("FAIL t3_sel_both: got err=%b sel=%0d expected err=0 sel=%0d", err, dut.sel_q, SEL_B); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({change1, busy, credit} !== 6'b110001) begin n_fail++; $display("FAIL t3_cancel: got %b expected 110001", {change1, busy, credit}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({change1, busy, credit} !== 6'b0) begin n_fail++; $display("FAIL t3_drained: got %b expected 000000", {change1, busy, credit}); end
    endtask

    task automatic test_cancel_priority();
        int pulses;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_checks++; if ({get2, err, change1, coin_rej} !== 4'b0011) begin n_fail++; $display("FAIL t4_cancel_wins: got %b expected 0011", {get2, err, change1, coin_rej}); end
        n_checks++; if (credit !== 4'd5) begin n_fail++; $display("FAIL t4_credit: got %0d expected 5", credit); end
        pulses = 1;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (change1) pulses++;
        end
        n_checks++; if (pulses !== 5) begin n_fail++; $display("FAIL t4_pulses: got %0d expected 5", pulses); end
        n_checks++; if ((dut.sel_q !== SEL_NONE) || (dut.state_q !== ST_IDLE)) begin n_fail++; $display("FAIL t4_cleared: got sel=%0d state=%0d expected 0 0", dut.sel_q, dut.state_q); end
    endtask

    task automatic test_saturation();
        int pulses;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (credit !== 4'd14) begin n_fail++; $display("FAIL t5_credit14: got %0d expected 14", credit); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({coin_rej, credit} !== 5'b11110) begin n_fail++; $display("FAIL t5_rej5: got rej=%b credit=%0d expected rej=1 credit=14", coin_rej, credit); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({coin_rej, credit} !== 5'b01111) begin n_fail++; $display("FAIL t5_fill15: got rej=%b credit=%0d expected rej=0 credit=15", coin_rej, credit); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({coin_rej, credit} !== 5'b11111) begin n_fail++; $display("FAIL t5_rej1: got rej=%b credit=%0d expected rej=1 credit=15", coin_rej, credit); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pulses = change1 ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (change1) pulses++;
        end
        n_checks++; if ((pulses !== 15) || (credit !== 4'd0)) begin n_fail++; $display("FAIL t5_refund15: got pulses=%0d credit=%0d expected 15 0", pulses, credit); end
        // both coins from empty add 6; sure with no selection bounces the coin and errs
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (credit !== 4'd6) begin n_fail++; $display("FAIL t5_both_coins: got %0d expected 6", credit); end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if ({err, coin_rej, credit} !== 6'b110110) begin n_fail++; $display("FAIL t5_coin_sure: got %b expected 110110", {err, coin_rej, credit}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_refund();
        int stray;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (credit !== 4'd8) begin n_fail++; $display("FAIL t6_credit8: got %0d expected 8", credit); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if ({change1, credit} !== 5'b10111) begin n_fail++; $display("FAIL t6_refund2: got %b expected 10111", {change1, credit}); end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        n_checks++; if ({change1, busy, credit} !== 6'b0) begin n_fail++; $display("FAIL t6_reset: got %b expected 000000", {change1, busy, credit}); end
        n_checks++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL t6_idle: got %0d expected %0d", dut.state_q, ST_IDLE); end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (change1 || busy) stray++;
        end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL t6_no_pulses: got %0d expected 0", stray); end
    endtask

    initial begin
        test_reset();
        test_exact_get6();
        test_get2_refund();
        test_err();
        test_cancel_priority();
        test_saturation();
        test_reset_mid_refund();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
